fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch stage of the three-stage RISC-V pipeline.
- Drives the PC-select mux code: reset vector, hold, PC+4, redirect target.
- Walks the core through reset, boot-load and run, and inserts kill bubbles after control-flow redirects.
- Arbitrates the IMEM write port (port A) between the boot program loader and the MEM-stage store path.

---
 rtl/fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_fetch_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: reset/boot/run/flush state machine,
// PC-select and kill generation, and IMEM port-A arbitration between loader and store path.
module fetch_ctrl #(
    parameter int FLUSH_CYCLES  = 1,
    parameter bit BOOT_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_go,
    input  logic        stall_req,
    input  logic        redirect_valid,
    input  logic        ld_req,
    input  logic [13:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic [3:0]  ld_be,
    input  logic        st_req,
    input  logic [13:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_be,
    output logic        ld_gnt,
    output logic        st_gnt,
    output logic [3:0]  imem_wea,
    output logic [13:0] imem_addra,
    output logic [31:0] imem_dina,
    output logic [1:0]  pc_sel,
    output logic        inst_kill,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_RESET = 2'b00,
        S_BOOT  = 2'b01,
        S_RUN   = 2'b10,
        S_FLUSH = 2'b11
    } state_t;

    localparam logic [1:0] PC_RST  = 2'b00;
    localparam logic [1:0] PC_HOLD = 2'b01;
    localparam logic [1:0] PC_INC  = 2'b10;
    localparam logic [1:0] PC_REDIR = 2'b11;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t     state;
    logic [2:0] flush_cnt;
    logic       boot_phase;

    // Valid/ready: a request is accepted only in a cycle where its grant is high;
    // an ungranted requester keeps its request and payload stable until granted.

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RESET;
            flush_cnt <= 3'd0;
        end else begin
            case (state)
                S_RESET: state <= BOOT_ON_RESET ? S_BOOT : S_RUN;
                S_BOOT: begin
                    if (boot_go)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (redirect_valid) begin
                        state     <= S_FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end
                end
                S_FLUSH: begin
                    if (redirect_valid) begin
                        flush_cnt <= FLUSH_LOAD;
                    end else if (!stall_req) begin
                        // Stalled cycles do not count toward the bubble budget.
                        if (flush_cnt <= 3'd1) begin
                            flush_cnt <= 3'd0;
                            state     <= S_RUN;
                        end else begin
                            flush_cnt <= flush_cnt - 3'd1;
                        end
                    end
                end
                default: state <= S_RESET;
            endcase
        end
    end

    assign boot_phase = (state == S_RESET) || (state == S_BOOT);
    assign state_o    = state;

    always_comb begin
        pc_sel    = PC_RST;
        inst_kill = 1'b1;
        if (!rst && !boot_phase) begin
            if (redirect_valid)
                pc_sel = PC_REDIR;
            else if (stall_req)
                pc_sel = PC_HOLD;
            else
                pc_sel = PC_INC;
            inst_kill = (state == S_FLUSH) || redirect_valid;
        end
    end

    always_comb begin
        ld_gnt     = 1'b0;
        st_gnt     = 1'b0;
        imem_wea   = 4'h0;
        imem_addra = 14'h0;
        imem_dina  = 32'h0;
        if (!rst) begin
            if (boot_phase) begin
                ld_gnt = ld_req;
            end else begin
                st_gnt = st_req;
                ld_gnt = ld_req & ~st_req;
            end
        end
        if (st_gnt) begin
            imem_wea   = st_be;
            imem_addra = st_addr;
            imem_dina  = st_data;
        end else if (ld_gnt) begin
            imem_wea   = ld_be;
            imem_addra = ld_addr;
            imem_dina  = ld_data;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with FLUSH_CYCLES=2 and boot enabled after reset.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        boot_go, stall_req, redirect_valid;
    logic        ld_req, st_req;
    logic [13:0] ld_addr, st_addr;
    logic [31:0] ld_data, st_data;
    logic [3:0]  ld_be, st_be;
    logic        ld_gnt, st_gnt, inst_kill;
    logic [3:0]  imem_wea;
    logic [13:0] imem_addra;
    logic [31:0] imem_dina;
    logic [1:0]  pc_sel, state_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.FLUSH_CYCLES(2), .BOOT_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .boot_go(boot_go), .stall_req(stall_req),
        .redirect_valid(redirect_valid),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .ld_gnt(ld_gnt), .st_gnt(st_gnt),
        .imem_wea(imem_wea), .imem_addra(imem_addra), .imem_dina(imem_dina),
        .pc_sel(pc_sel), .inst_kill(inst_kill), .state_o(state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_core(input string tag, input logic [1:0] st, input logic [1:0] ps,
                              input logic kill);
        #1;
        check({tag, "_state"}, 32'(state_o), 32'(st));
        check({tag, "_pc_sel"}, 32'(pc_sel), 32'(ps));
        check({tag, "_kill"}, 32'(inst_kill), 32'(kill));
    endtask

    initial begin
        rst = 1'b1; boot_go = 0; stall_req = 0; redirect_valid = 0;
        ld_req = 1'b1; ld_addr = 14'h0; ld_data = 32'h0; ld_be = 4'h0;
        st_req = 1'b0; st_addr = 14'h0; st_data = 32'h0; st_be = 4'h0;

        // Reset: grants suppressed even with a pending loader request
        #2;
        check_core("rst", 2'b00, 2'b00, 1'b1);
        check("rst_ld_gnt", 32'(ld_gnt), 32'd0);
        check("rst_wea", 32'(imem_wea), 32'd0);
        ld_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_core("reset_state", 2'b00, 2'b00, 1'b1);
        step();

        for (int i = 0; i < 5; i++) begin
            check_core($sformatf("boot%0d", i), 2'b01, 2'b00, 1'b1);
            step();
        end

        // Boot arbitration: loader wins even with store requesting
        ld_req = 1; ld_addr = 14'h0010; ld_data = 32'h00000013; ld_be = 4'hF;
        st_req = 1; st_addr = 14'h0200; st_data = 32'hDEADBEEF; st_be = 4'h1;
        #1;
        check("boot_ld_gnt", 32'(ld_gnt), 32'd1);
        check("boot_st_gnt", 32'(st_gnt), 32'd0);
        check("boot_wea", 32'(imem_wea), 32'hF);
        check("boot_addra", 32'(imem_addra), 32'h0010);
        check("boot_dina", imem_dina, 32'h00000013);
        ld_req = 0; st_req = 0;

        boot_go = 1'b1;
        step();
        boot_go = 1'b0;
        check_core("run_entry", 2'b10, 2'b10, 1'b0);

        // Redirect with two kill bubbles afterwards
        redirect_valid = 1'b1;
        check_core("redir", 2'b10, 2'b11, 1'b1);
        step();
        redirect_valid = 1'b0;
        check_core("flush1", 2'b11, 2'b10, 1'b1);
        step();
        check_core("flush2", 2'b11, 2'b10, 1'b1);
        step();
        check_core("flush_done", 2'b10, 2'b10, 1'b0);

        // Stall plus redirect: redirect wins, stall freezes the counter
        stall_req = 1'b1; redirect_valid = 1'b1;
        check_core("stall_redir", 2'b10, 2'b11, 1'b1);
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_core($sformatf("flush_stall%0d", i), 2'b11, 2'b01, 1'b1);
            step();
        end
        stall_req = 1'b0;
        check_core("flush_unstall1", 2'b11, 2'b10, 1'b1);
        step();
        check_core("flush_unstall2", 2'b11, 2'b10, 1'b1);
        step();
        check_core("stall_flush_done", 2'b10, 2'b10, 1'b0);

        // Redirect inside FLUSH reloads the counter
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        step();
        redirect_valid = 1'b1;
        check_core("reredir", 2'b11, 2'b11, 1'b1);
        step();
        redirect_valid = 1'b0;
        check_core("reload1", 2'b11, 2'b10, 1'b1);
        step();
        check_core("reload2", 2'b11, 2'b10, 1'b1);
        step();
        check_core("reload_done", 2'b10, 2'b10, 1'b0);

        // Run arbitration: store has priority, loader granted once store drops
        st_req = 1; st_addr = 14'h0100; st_data = 32'hCAFE0001; st_be = 4'h3;
        ld_req = 1; ld_addr = 14'h0020; ld_data = 32'h12345678; ld_be = 4'hC;
        #1;
        check("run_st_gnt", 32'(st_gnt), 32'd1);
        check("run_ld_gnt", 32'(ld_gnt), 32'd0);
        check("run_st_wea", 32'(imem_wea), 32'h3);
        check("run_st_addra", 32'(imem_addra), 32'h0100);
        check("run_st_dina", imem_dina, 32'hCAFE0001);
        st_req = 0;
        #1;
        check("run_ld_gnt2", 32'(ld_gnt), 32'd1);
        check("run_st_gnt2", 32'(st_gnt), 32'd0);
        check("run_ld_wea", 32'(imem_wea), 32'hC);
        check("run_ld_addra", 32'(imem_addra), 32'h0020);
        ld_req = 0;
        #1;
        check("idle_wea", 32'(imem_wea), 32'h0);
        check("idle_addra", 32'(imem_addra), 32'h0);
        check("idle_dina", imem_dina, 32'h0);

        // Async reset between edges while in FLUSH
        step();
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        ld_req = 1'b1; st_req = 1'b1;
        #1;
        check("pre_rst_state", 32'(state_o), 32'h3);
        rst = 1'b1;
        check_core("async_rst", 2'b00, 2'b00, 1'b1);
        check("async_rst_wea", 32'(imem_wea), 32'h0);
        check("async_rst_ld_gnt", 32'(ld_gnt), 32'd0);
        check("async_rst_st_gnt", 32'(st_gnt), 32'd0);
        ld_req = 0; st_req = 0;
        step();
        rst = 1'b0;
        step();
        check_core("post_rst_boot", 2'b01, 2'b00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
